dmem_responder: RTL and testbench

Shared data-memory responder at the far end of the L1 miss/store path. It serves two L1 cache controllers (one per core) over a valid/ready request and one-cycle response pulse protocol. It arbitrates round-robin, performs byte/half/word merged writes and aligned word reads on a 256-word array, and returns read data after a fixed latency. It replaces the combinational dmem port that the L1 controllers currently see.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_responder_rr_arbiter_2.sv | 27 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types, constants and store-merge helper for the data-memory responder
// and the L1 store path.
package dmem_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MSK_W     = 3;
    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned WIDX_W    = 8;
    localparam int unsigned NUM_WORDS = 256;
    localparam int unsigned CNT_W     = 3;

    localparam logic [MSK_W-1:0] MASK_B = 3'b000;
    localparam logic [MSK_W-1:0] MASK_H = 3'b001;
    localparam logic [MSK_W-1:0] MASK_W = 3'b010;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MSK_W-1:0]  mask;
    } dmem_req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    // Byte/half/word lane merge of right-aligned store data; unknown masks leave the word intact.
    function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [1:0]        lane,
                                                     input logic [MSK_W-1:0]  mask);
        logic [DATA_W-1:0] merged;
        merged = old_word;
        case (mask)
            MASK_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            MASK_H: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            MASK_W:  merged = wdata;
            default: merged = old_word;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Two-port L1-to-dmem request/response bundle.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0]             req_we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0][MSK_W-1:0]  req_mask;
    logic [NUM_PORTS-1:0]             req_ready;
    logic [NUM_PORTS-1:0]             resp_valid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] resp_rdata;

    modport master (output req_valid, req_we, req_addr, req_wdata, req_mask,
                    input  req_ready, resp_valid, resp_rdata);

    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_mask,
                    output req_ready, resp_valid, resp_rdata);

endinterface

// File: rtl/dmem_responder_rr_arbiter_2.sv
// Two-requester round-robin arbiter; a tie goes to the port that was not granted last.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant_c
);

    logic r_last_grant;

    always_ff @(posedge clk) begin
        if (reset)         r_last_grant <= 1'b1;
        else if (i_accept) r_last_grant <= o_grant_c[1];
    end

    always_comb begin
        o_grant_c = 2'b00;
        case (i_req)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Shared data-memory responder: arbitrates two L1 ports, merges stores into a
// 256-word array and returns reads after READ_LATENCY cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned WAIT_LOAD = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

    resp_state_t                      r_state, w_state_nxt;
    logic [CNT_W-1:0]                 r_cnt, w_cnt_nxt;
    logic                             r_port;
    logic [WIDX_W-1:0]                r_widx;
    logic [DATA_W-1:0]                r_mem [NUM_WORDS];
    logic [NUM_PORTS-1:0]             r_resp_valid, w_resp_valid_nxt;
    logic [NUM_PORTS-1:0][DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;

    logic [NUM_PORTS-1:0] w_arb_grant, w_grant;
    logic                 w_accept, w_gport, w_rd_port;
    dmem_req_t            w_sel;
    logic [WIDX_W-1:0]    w_sel_widx, w_rd_widx;

    rr_arbiter_2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (bus.req_valid),
        .i_accept  (w_accept),
        .o_grant_c (w_arb_grant)
    );

    // Grant is a subset of valid, so any grant bit is a handshake.
    assign w_grant       = (r_state == IDLE && !reset) ? w_arb_grant : 2'b00;
    assign bus.req_ready = w_grant;
    assign w_accept      = |w_grant;
    assign w_gport       = w_grant[1];
    assign w_sel         = '{we:    bus.req_we[w_gport],
                             addr:  bus.req_addr[w_gport],
                             wdata: bus.req_wdata[w_gport],
                             mask:  bus.req_mask[w_gport]};
    assign w_sel_widx    = w_sel.addr[ADDR_W-1:2];
    assign w_rd_port     = w_accept ? w_gport : r_port;
    assign w_rd_widx     = w_accept ? w_sel_widx : r_widx;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_resp_valid_nxt = '0;
        w_resp_rdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_sel.we || READ_LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_W'(WAIT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) w_state_nxt = RESP;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Response is captured on the edge entering RESP; stores ack with zero data.
        if (w_state_nxt == RESP && r_state != RESP) begin
            w_resp_valid_nxt[w_rd_port] = 1'b1;
            if (!(w_accept && w_sel.we)) w_resp_rdata_nxt[w_rd_port] = r_mem[w_rd_widx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_port       <= 1'b0;
            r_widx       <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            if (w_accept) begin
                r_port <= w_gport;
                r_widx <= w_sel_widx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_accept && w_sel.we) begin
            r_mem[w_sel_widx] <= merge_word(r_mem[w_sel_widx], w_sel.wdata, w_sel.addr[1:0], w_sel.mask);
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;

    // A waiting requester may withdraw, but must not alter its fields while still valid.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req_stable
        a_req_stable: assert property (@(posedge clk) disable iff (reset)
            (bus.req_valid[p] && !bus.req_ready[p]) |=>
            (!bus.req_valid[p] || ($stable(bus.req_we[p]) && $stable(bus.req_addr[p]) &&
                                   $stable(bus.req_wdata[p]) && $stable(bus.req_mask[p]))));
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency-2 instance plus a latency-1 instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [1:0]  rdy, vs, va;
    int          lat;
    logic [31:0] data, other;

    dmem_responder_if bus ();
    dmem_responder_if bus1 ();

    dmem_responder #(.READ_LATENCY(2)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    dmem_responder #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on port p, wait up to 10 cycles for its response pulse.
    task automatic run_xact(input logic sel, input logic p, input logic we, input logic [9:0] a,
                            input logic [31:0] d, input logic [2:0] m);
        logic [1:0]       rv;
        logic [1:0][31:0] rd;
        if (!sel) begin
            bus.req_we[p] = we; bus.req_addr[p] = a; bus.req_wdata[p] = d;
            bus.req_mask[p] = m; bus.req_valid[p] = 1'b1;
        end else begin
            bus1.req_we[p] = we; bus1.req_addr[p] = a; bus1.req_wdata[p] = d;
            bus1.req_mask[p] = m; bus1.req_valid[p] = 1'b1;
        end
        #1;
        rdy = sel ? bus1.req_ready : bus.req_ready;
        tick();
        if (!sel) bus.req_valid[p] = 1'b0;
        else      bus1.req_valid[p] = 1'b0;
        lat = 0; vs = 2'b00; data = '0; other = '0;
        for (int c = 1; c <= 10; c++) begin
            rv = sel ? bus1.resp_valid : bus.resp_valid;
            rd = sel ? bus1.resp_rdata : bus.resp_rdata;
            if (rv != 2'b00) begin
                lat = c; vs = rv; data = rd[p]; other = rd[~p];
                break;
            end
            tick();
        end
        tick();
        va = sel ? bus1.resp_valid : bus.resp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        bus.req_valid = 2'b11;
        #1;
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", bus.req_ready); end
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b want=00", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.resp_rdata); end
        tick();
        reset = 1'b0;
        bus.req_valid = 2'b00;
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL rst_after_rvalid got=%b want=00", bus.resp_valid); end
        run_xact(1'b0, 1'b0, 1'b0, 10'h010, 32'h0, MASK_W);
        total++; if (rdy !== 2'b01) begin bad++; $display("FAIL first_rd_ready got=%b want=01", rdy); end
        total++; if (lat !== 2) begin bad++; $display("FAIL first_rd_lat got=%0d want=2", lat); end
        total++; if (vs !== 2'b01) begin bad++; $display("FAIL first_rd_vld got=%b want=01", vs); end
        total++; if (data !== 32'h0 || other !== 32'h0) begin bad++; $display("FAIL first_rd_data got=%h/%h want=0/0", data, other); end
    endtask

    task automatic test_store_read();
        run_xact(1'b0, 1'b0, 1'b1, 10'h024, 32'hDEADBEEF, MASK_W);
        total++; if (rdy !== 2'b01) begin bad++; $display("FAIL st_ready got=%b want=01", rdy); end
        total++; if (lat !== 1) begin bad++; $display("FAIL st_lat got=%0d want=1", lat); end
        total++; if (vs !== 2'b01 || data !== 32'h0) begin bad++; $display("FAIL st_ack got=%b/%h want=01/0", vs, data); end
        total++; if (va !== 2'b00) begin bad++; $display("FAIL st_pulse got=%b want=00", va); end
        run_xact(1'b0, 1'b1, 1'b0, 10'h024, 32'h0, MASK_B);
        total++; if (rdy !== 2'b10) begin bad++; $display("FAIL rd1_ready got=%b want=10", rdy); end
        total++; if (lat !== 2 || vs !== 2'b10) begin bad++; $display("FAIL rd1_timing got=%0d/%b want=2/10", lat, vs); end
        total++; if (data !== 32'hDEADBEEF || other !== 32'h0) begin bad++; $display("FAIL rd1_data got=%h/%h want=deadbeef/0", data, other); end
    endtask

    task automatic test_merge();
        logic [9:0]  ta [6] = '{10'h025, 10'h026, 10'h027, 10'h024, 10'h024, 10'h024};
        logic [31:0] td [6] = '{32'h000000AA, 32'h00001234, 32'h00000077, 32'hFFFF5678, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [2:0]  tm [6] = '{MASK_B, MASK_H, MASK_B, MASK_H, 3'b011, 3'b111};
        logic [31:0] te [6] = '{32'hDEADAAEF, 32'h1234AAEF, 32'h7734AAEF, 32'h77345678, 32'h77345678, 32'h77345678};
        for (int k = 0; k < 6; k++) begin
            run_xact(1'b0, 1'b0, 1'b1, ta[k], td[k], tm[k]);
            total++; if (lat !== 1 || vs !== 2'b01) begin bad++; $display("FAIL mrg_ack[%0d] got=%0d/%b want=1/01", k, lat, vs); end
            run_xact(1'b0, 1'b1, 1'b0, ta[k], 32'h0, 3'b111);
            total++; if (vs !== 2'b10) begin bad++; $display("FAIL mrg_rvld[%0d] got=%b want=10", k, vs); end
            total++; if (data !== te[k]) begin bad++; $display("FAIL mrg_data[%0d] got=%h want=%h", k, data, te[k]); end
        end
    endtask

    task automatic test_round_robin();
        int   acc_c [6] = '{default: 0};
        logic acc_p [6] = '{default: 1'b0};
        int   n = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_we = 2'b00; bus.req_addr[0] = 10'h024; bus.req_addr[1] = 10'h000;
        bus.req_mask = '0; bus.req_wdata = '0; bus.req_valid = 2'b11;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                total++; if (bus.req_ready !== 2'b01 && bus.req_ready !== 2'b10) begin bad++; $display("FAIL rr_onehot got=%b want=01|10", bus.req_ready); end
                if (n < 6) begin acc_c[n] = c; acc_p[n] = bus.req_ready[1]; n++; end
            end
            tick();
            if (n == 6) break;
        end
        bus.req_valid = 2'b00;
        repeat (4) tick();
        total++; if (n !== 6) begin bad++; $display("FAIL rr_count got=%0d want=6", n); end
        for (int k = 0; k < 6; k++) begin
            total++; if (acc_p[k] !== 1'(k % 2)) begin bad++; $display("FAIL rr_port[%0d] got=%b want=%0d", k, acc_p[k], k % 2); end
        end
        for (int k = 1; k < 6; k++) begin
            total++; if (acc_c[k] - acc_c[k-1] !== 3) begin bad++; $display("FAIL rr_gap[%0d] got=%0d want=3", k, acc_c[k] - acc_c[k-1]); end
        end
    endtask

    task automatic test_lat1_back_to_back();
        int          acc_c [4] = '{default: 0};
        int          rsp_c [4] = '{default: 0};
        logic [31:0] rsp_d [4] = '{default: 32'h0};
        int          na = 0;
        int          nr = 0;
        run_xact(1'b1, 1'b1, 1'b1, 10'h008, 32'hCAFEF00D, MASK_W);
        total++; if (rdy !== 2'b10 || lat !== 1) begin bad++; $display("FAIL l1_st got=%b/%0d want=10/1", rdy, lat); end
        bus1.req_we[0] = 1'b0; bus1.req_addr[0] = 10'h008; bus1.req_mask[0] = MASK_W; bus1.req_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus1.req_ready[0] && na < 4) begin acc_c[na] = c; na++; end
            if (bus1.resp_valid[0] && nr < 4) begin rsp_c[nr] = c; rsp_d[nr] = bus1.resp_rdata[0]; nr++; end
            tick();
        end
        bus1.req_valid[0] = 1'b0;
        repeat (2) tick();
        total++; if (na !== 4 || nr !== 4) begin bad++; $display("FAIL l1_count got=%0d/%0d want=4/4", na, nr); end
        for (int k = 1; k < 4; k++) begin
            total++; if (acc_c[k] - acc_c[k-1] !== 2) begin bad++; $display("FAIL l1_gap[%0d] got=%0d want=2", k, acc_c[k] - acc_c[k-1]); end
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (rsp_c[k] !== acc_c[k] + 1) begin bad++; $display("FAIL l1_lat[%0d] got=%0d want=%0d", k, rsp_c[k], acc_c[k] + 1); end
            total++; if (rsp_d[k] !== 32'hCAFEF00D) begin bad++; $display("FAIL l1_data[%0d] got=%h want=cafef00d", k, rsp_d[k]); end
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen = 1'b0;
        bus.req_we[0] = 1'b0; bus.req_addr[0] = 10'h024; bus.req_mask[0] = MASK_W; bus.req_valid[0] = 1'b1;
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL riw_ready got=%b want=01", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        reset = 1'b1;
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL riw_wait_vld got=%b want=00", bus.resp_valid); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.resp_valid != 2'b00) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL riw_dropped got=%b want=0", seen); end
        run_xact(1'b0, 1'b0, 1'b0, 10'h024, 32'h0, MASK_W);
        total++; if (rdy !== 2'b01 || lat !== 2 || vs !== 2'b01) begin bad++; $display("FAIL riw_post got=%b/%0d/%b want=01/2/01", rdy, lat, vs); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL riw_clear got=%h want=0", data); end
        run_xact(1'b1, 1'b0, 1'b0, 10'h008, 32'h0, MASK_W);
        total++; if (lat !== 1 || data !== 32'h0) begin bad++; $display("FAIL riw_l1_clear got=%0d/%h want=1/0", lat, data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid  = '0; bus.req_we  = '0; bus.req_addr  = '0; bus.req_wdata  = '0; bus.req_mask  = '0;
        bus1.req_valid = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_mask = '0;
        test_reset();
        test_store_read();
        test_merge();
        test_round_robin();
        test_lat1_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
